// File: rtl/sdp_y_alu_op_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : sdp_y_alu_op_arb_if
//  Brief    : Operand channel and ALU-operand handshake bundle for the
//             SDP Y ALU operand arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface sdp_y_alu_op_arb_if #(
    parameter int WIDTH = 128
);
    logic [WIDTH-1:0] chn0_z;
    logic [WIDTH-1:0] chn1_z;
    logic             chn0_vz;
    logic             chn1_vz;
    logic             chn0_lz;
    logic             chn1_lz;
    logic [WIDTH-1:0] alu_op_pd;
    logic             alu_op_src;
    logic             alu_op_vld;
    logic             alu_op_rdy;

    // Producer/consumer side: supplies operands, consumes ALU operands
    modport master (
        output chn0_z, chn1_z, chn0_vz, chn1_vz, alu_op_rdy,
        input  chn0_lz, chn1_lz, alu_op_pd, alu_op_src, alu_op_vld
    );

    // Arbiter side
    modport slave (
        input  chn0_z, chn1_z, chn0_vz, chn1_vz, alu_op_rdy,
        output chn0_lz, chn1_lz, alu_op_pd, alu_op_src, alu_op_vld
    );
endinterface
`default_nettype wire

// File: rtl/sdp_y_alu_op_arb.sv
`default_nettype none
// ============================================================================
//  Module   : sdp_y_alu_op_arb
//  Brief    : Selects operands from two input channels (fixed or round-robin),
//             counts them per layer and buffers them in a small FIFO ahead of
//             the ALU core.
//  Revision : 1.0 - initial release
// ============================================================================
module sdp_y_alu_op_arb #(
    parameter int WIDTH      = 128,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic        nvdla_core_clk,
    input  wire logic        nvdla_core_rstn,   // active-high despite the name
    input  wire logic [1:0]  cfg_alu_src,
    input  wire logic [15:0] cfg_op_len,
    input  wire logic        op_en,
    sdp_y_alu_op_arb_if.slave bus,
    output logic             busy,
    output logic             layer_done
);

    localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_OPC_W  = 17;

    localparam logic [c_FCNT_W-1:0] c_DEPTH    = c_FCNT_W'(FIFO_DEPTH);
    localparam logic [c_FCNT_W-1:0] c_FONE     = c_FCNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          r_src;
    logic [15:0]         r_len;
    logic [c_OPC_W-1:0]  r_opcnt;
    logic                r_prio;     // 0 = chn0 holds round-robin priority
    logic [WIDTH:0]      r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FCNT_W-1:0] r_count;

    logic w_run, w_room, w_more;
    logic w_allow0, w_allow1, w_elig0, w_elig1;
    logic w_gnt0, w_gnt1, w_push, w_pop, w_last;

    // Eligibility and grant; full FIFO blocks grants even if it pops this cycle
    always_comb begin
        w_run    = (r_state == c_RUN);
        w_room   = (r_count < c_DEPTH);
        w_more   = (r_opcnt <= {1'b0, r_len});
        w_allow0 = (r_src != 2'd1);                   // modes 0, 2 and 3
        w_allow1 = (r_src == 2'd1) || (r_src == 2'd2);
        w_elig0  = w_run & bus.chn0_vz & w_allow0 & w_room & w_more;
        w_elig1  = w_run & bus.chn1_vz & w_allow1 & w_room & w_more;
        // Both can only be eligible in round-robin mode; priority breaks the tie
        w_gnt0   = w_elig0 & ~(w_elig1 & r_prio);
        w_gnt1   = w_elig1 & ~(w_elig0 & ~r_prio);
        w_push   = w_gnt0 | w_gnt1;
        w_pop    = (r_count != '0) & bus.alu_op_rdy;
        w_last   = w_push & (r_opcnt == {1'b0, r_len});
    end

    assign bus.chn0_lz    = w_gnt0;
    assign bus.chn1_lz    = w_gnt1;
    assign bus.alu_op_vld = (r_count != '0);
    assign bus.alu_op_pd  = r_mem[r_rd_ptr][WIDTH-1:0];
    assign bus.alu_op_src = r_mem[r_rd_ptr][WIDTH];
    assign busy           = (r_state != c_IDLE);

    // Layer control: state, latched config, operand counter, priority, done pulse
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rstn) begin
        if (nvdla_core_rstn) begin
            r_state    <= c_IDLE;
            r_src      <= 2'd0;
            r_len      <= 16'd0;
            r_opcnt    <= '0;
            r_prio     <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            layer_done <= 1'b0;
            if (w_push) begin
                r_opcnt <= r_opcnt + c_OPC_W'(1);
                r_prio  <= ~r_prio;
            end
            case (r_state)
                c_IDLE: begin
                    if (op_en) begin
                        r_state <= c_RUN;
                        r_src   <= cfg_alu_src;
                        r_len   <= cfg_op_len;
                        r_opcnt <= '0;
                        r_prio  <= 1'b0;
                    end
                end
                c_RUN: begin
                    if (w_last) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    // No pushes happen here, so a pop of the last entry empties it
                    if (w_pop && (r_count == c_FONE)) begin
                        r_state    <= c_IDLE;
                        layer_done <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Output FIFO: circular buffer holding {source, operand}
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rstn) begin
        if (nvdla_core_rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_gnt1 ? {1'b1, bus.chn1_z} : {1'b0, bus.chn0_z};
                r_wr_ptr        <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_FONE;
                2'b01:   r_count <= r_count - c_FONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sdp_y_alu_op_arb.md
SDP_Y_ALU_OP_ARB -- requirements
Module: sdp_y_alu_op_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 128, operand width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, number of output buffer entries.
REQ-003 SHALL have port nvdla_core_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port nvdla_core_rstn, input, 1 bit: asynchronous active-high reset; asserted = 1 despite the port name.
REQ-005 SHALL have port cfg_alu_src, input, 2 bits: 0 = chn0 only, 1 = chn1 only, 2 = round-robin, 3 = treated as 0.
REQ-006 SHALL have port cfg_op_len, input, 16 bits: operands per layer minus one.
REQ-007 SHALL have port op_en, input, 1 bit: layer start pulse.
REQ-008 SHALL have ports chn0_z (input, WIDTH bits) and chn1_z (input, WIDTH bits): operand data.
REQ-009 SHALL have ports chn0_vz and chn1_vz, input, 1 bit each: operand valid.
REQ-010 SHALL have ports chn0_lz and chn1_lz, output, 1 bit each: load strobe; data is consumed in the same cycle.
REQ-011 SHALL have port alu_op_pd, output, WIDTH bits: operand to the ALU core.
REQ-012 SHALL have port alu_op_src, output, 1 bit: channel that supplied alu_op_pd.
REQ-013 SHALL have port alu_op_vld, output, 1 bit; and port alu_op_rdy, input, 1 bit: consumer handshake.
REQ-014 SHALL have port busy, output, 1 bit: a layer is in progress.
REQ-015 SHALL have port layer_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DRAIN.
REQ-017 SHALL move from IDLE to RUN on op_en=1, latching cfg_alu_src and cfg_op_len and clearing the operand counter.
REQ-018 SHALL ignore op_en outside IDLE; cfg_* changes during a layer SHALL have no effect.
REQ-019 SHALL define a channel as eligible in RUN when its vz=1, it is permitted by the latched source mode, the FIFO count < FIFO_DEPTH, and counter <= latched len.
REQ-020 SHALL, in round-robin mode, grant the eligible channel holding priority; if only one channel is eligible it is granted; priority SHALL toggle to the other channel after each grant.
REQ-021 SHALL reset round-robin priority to chn0 at every layer start.
REQ-022 SHALL assert chnX_lz combinationally in the grant cycle only, with at most one lz high per cycle and never while vz=0.
REQ-023 SHALL push {source, chnX_z} into the FIFO on each grant and increment the counter by 1.
REQ-024 SHALL NOT grant when the FIFO is full, even if the FIFO pops in the same cycle (no full-bypass).
REQ-025 SHALL assert alu_op_vld when FIFO count > 0, with alu_op_pd/alu_op_src taken from the head entry; an entry pops when alu_op_vld & alu_op_rdy.
REQ-026 SHALL support push and pop in the same cycle when not full; count is then unchanged.
REQ-027 SHALL present operand data granted in cycle N at alu_op_pd in cycle N+1 when the FIFO was empty (one-cycle latency).
REQ-028 SHALL hold alu_op_pd stable while alu_op_vld=1 and alu_op_rdy=0.
REQ-029 SHALL move from RUN to DRAIN on the cycle the (len+1)th operand is granted.
REQ-030 SHALL, in DRAIN, pulse layer_done for one cycle and return to IDLE on the cycle the FIFO becomes empty through a pop.
REQ-031 SHALL drive busy=1 in RUN and DRAIN, and 0 in IDLE.
REQ-032 SHALL use a 17-bit counter so that len=0xFFFF (65536 operands) does not wrap.
REQ-033 SHALL stop granting in DRAIN even when vz=1.

Reset
REQ-034 SHALL, while reset is asserted, force: FSM=IDLE, FIFO count=0, counter=0, priority=chn0, latched config=0; outputs lz=0, alu_op_vld=0, alu_op_pd=0, alu_op_src=0, busy=0, layer_done=0.
REQ-035 SHALL, on reset asserted mid-layer, discard buffered operands, emit no layer_done, and accept op_en only from the first clock edge after deassertion.

Verification
REQ-036 SHALL be verified with: mode 2, len=3, both vz=1 always, rdy=1 -> lz order chn0,chn1,chn0,chn1; src 0,1,0,1 one cycle later; layer_done one cycle after the 4th pop.
REQ-037 SHALL be verified with: mode 0, len=1, chn1_vz=1 -> chn1_lz never asserts; only chn0 data is delivered.
REQ-038 SHALL be verified with: rdy=0 for 5 cycles, vz=1 -> exactly 2 grants, then lz=0 while full; pd held; grants resume the cycle after the first pop.
REQ-039 SHALL be verified with: op_en pulsed during RUN -> no effect; total grants = len+1.
REQ-040 SHALL be verified with: reset asserted with 2 entries buffered -> vld=0 immediately (asynchronous), busy=0, no layer_done.
REQ-041 SHALL be verified with: mode 2 with only chn1 valid -> chn1 is granted every cycle and priority still toggles.
